rob_commit_unit: RTL and testbench

- In-order retire side of the ROB; the reader of the per-entry state that enqueue and writeback write into each ROB entry.
- Tracks the head pointer and scans the two oldest entries each cycle.
- Commits up to 2 ready entries per cycle by pulsing a per-entry commit vector.
- Drives registered commit ports to the RAT, freelist and difftest, plus a single registered BHT/BTB update port to the frontend.

---
 rtl/rob_pkg.sv | 54 +++++
 rtl/rob_commit_unit_if.sv | 57 +++++
 rtl/rob_head_sel.sv | 55 +++++
 rtl/rob_commit_unit.sv | 191 +++++++++++++++++++
 tb/tb_rob_commit_unit.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared ROB widths, commit-field bundle and commit-source encoding.
// Imported by the commit unit, its head selector and the commit interface.
package rob_pkg;

    localparam int unsigned ROB_DEPTH_DEF      = 64;
    localparam int unsigned PTR_W_DEF          = $clog2(ROB_DEPTH_DEF) + 1;

    localparam int unsigned PC_WIDTH           = 32;
    localparam int unsigned INSTR_WIDTH        = 32;
    localparam int unsigned LREG_WIDTH         = 5;
    localparam int unsigned PREG_WIDTH         = 6;
    localparam int unsigned BHTBTB_INDEX_WIDTH = 9;
    localparam int unsigned BHT_SEL_WIDTH      = 2;
    localparam int unsigned BTB_WMASK_WIDTH    = 129;
    localparam int unsigned BTB_INDEX_WIDTH    = 9;
    localparam int unsigned BTB_DATA_WIDTH     = 129;

    typedef struct packed {
        logic                          we;
        logic [BHTBTB_INDEX_WIDTH-1:0] index;
        logic [BHT_SEL_WIDTH-1:0]      sel;
        logic                          inc;
        logic                          dec;
        logic                          valid;
    } rob_bht_upd_t;

    typedef struct packed {
        logic                       ce;
        logic                       we;
        logic [BTB_WMASK_WIDTH-1:0] wmask;
        logic [BTB_INDEX_WIDTH-1:0] index;
        logic [BTB_DATA_WIDTH-1:0]  din;
    } rob_btb_upd_t;

    typedef struct packed {
        logic                   ready;
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic [LREG_WIDTH-1:0]  lrd;
        logic [PREG_WIDTH-1:0]  prd;
        logic [PREG_WIDTH-1:0]  old_prd;
        logic                   need_to_wb;
        logic                   skip;
        rob_bht_upd_t           bht;
        rob_btb_upd_t           btb;
    } rob_commit_info_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_H0   = 2'd1,
        SRC_H1   = 2'd2
    } cm_src_e;

endpackage

// File: rtl/rob_commit_unit_if.sv
// Registered retire bundle: two commit ports plus the single BHT/BTB update port.
// master = rob_commit_unit (driver), slave = RAT/freelist/difftest/frontend.
interface rob_commit_unit_if;
    import rob_pkg::*;

    logic                          commit0_valid;
    logic [PC_WIDTH-1:0]           commit0_pc;
    logic [INSTR_WIDTH-1:0]        commit0_instr;
    logic [LREG_WIDTH-1:0]         commit0_lrd;
    logic [PREG_WIDTH-1:0]         commit0_prd;
    logic [PREG_WIDTH-1:0]         commit0_old_prd;
    logic                          commit0_need_to_wb;
    logic                          commit0_skip;

    logic                          commit1_valid;
    logic [PC_WIDTH-1:0]           commit1_pc;
    logic [INSTR_WIDTH-1:0]        commit1_instr;
    logic [LREG_WIDTH-1:0]         commit1_lrd;
    logic [PREG_WIDTH-1:0]         commit1_prd;
    logic [PREG_WIDTH-1:0]         commit1_old_prd;
    logic                          commit1_need_to_wb;
    logic                          commit1_skip;

    logic                          cm_bht_write_enable;
    logic [BHTBTB_INDEX_WIDTH-1:0] cm_bht_write_index;
    logic [BHT_SEL_WIDTH-1:0]      cm_bht_write_counter_select;
    logic                          cm_bht_write_inc;
    logic                          cm_bht_write_dec;
    logic                          cm_bht_valid_in;

    logic                          cm_btb_ce;
    logic                          cm_btb_we;
    logic [BTB_WMASK_WIDTH-1:0]    cm_btb_wmask;
    logic [BTB_INDEX_WIDTH-1:0]    cm_btb_write_index;
    logic [BTB_DATA_WIDTH-1:0]     cm_btb_din;

    modport master (
        output commit0_valid, commit0_pc, commit0_instr, commit0_lrd, commit0_prd,
               commit0_old_prd, commit0_need_to_wb, commit0_skip,
               commit1_valid, commit1_pc, commit1_instr, commit1_lrd, commit1_prd,
               commit1_old_prd, commit1_need_to_wb, commit1_skip,
               cm_bht_write_enable, cm_bht_write_index, cm_bht_write_counter_select,
               cm_bht_write_inc, cm_bht_write_dec, cm_bht_valid_in,
               cm_btb_ce, cm_btb_we, cm_btb_wmask, cm_btb_write_index, cm_btb_din
    );

    modport slave (
        input  commit0_valid, commit0_pc, commit0_instr, commit0_lrd, commit0_prd,
               commit0_old_prd, commit0_need_to_wb, commit0_skip,
               commit1_valid, commit1_pc, commit1_instr, commit1_lrd, commit1_prd,
               commit1_old_prd, commit1_need_to_wb, commit1_skip,
               cm_bht_write_enable, cm_bht_write_index, cm_bht_write_counter_select,
               cm_bht_write_inc, cm_bht_write_dec, cm_bht_valid_in,
               cm_btb_ce, cm_btb_we, cm_btb_wmask, cm_btb_write_index, cm_btb_din
    );

endinterface

// File: rtl/rob_head_sel.sv
// Combinational slot reader: picks entry i_idx out of the flattened per-entry
// vectors and returns it as one commit-info bundle.
module rob_head_sel
    import rob_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int unsigned IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic [IDX_W-1:0]                        i_idx,
    input  logic [ROB_DEPTH-1:0]                    i_ready,
    input  logic [ROB_DEPTH*PC_WIDTH-1:0]           i_pc,
    input  logic [ROB_DEPTH*INSTR_WIDTH-1:0]        i_instr,
    input  logic [ROB_DEPTH*LREG_WIDTH-1:0]         i_lrd,
    input  logic [ROB_DEPTH*PREG_WIDTH-1:0]         i_prd,
    input  logic [ROB_DEPTH*PREG_WIDTH-1:0]         i_old_prd,
    input  logic [ROB_DEPTH-1:0]                    i_need_to_wb,
    input  logic [ROB_DEPTH-1:0]                    i_skip,
    input  logic [ROB_DEPTH-1:0]                    i_bht_we,
    input  logic [ROB_DEPTH*BHTBTB_INDEX_WIDTH-1:0] i_bht_index,
    input  logic [ROB_DEPTH*BHT_SEL_WIDTH-1:0]      i_bht_sel,
    input  logic [ROB_DEPTH-1:0]                    i_bht_inc,
    input  logic [ROB_DEPTH-1:0]                    i_bht_dec,
    input  logic [ROB_DEPTH-1:0]                    i_bht_valid,
    input  logic [ROB_DEPTH-1:0]                    i_btb_ce,
    input  logic [ROB_DEPTH-1:0]                    i_btb_we,
    input  logic [ROB_DEPTH*BTB_WMASK_WIDTH-1:0]    i_btb_wmask,
    input  logic [ROB_DEPTH*BTB_INDEX_WIDTH-1:0]    i_btb_index,
    input  logic [ROB_DEPTH*BTB_DATA_WIDTH-1:0]     i_btb_din,
    output rob_commit_info_t                        o_info
);

    always_comb begin
        o_info            = '0;
        o_info.ready      = i_ready[i_idx];
        o_info.pc         = i_pc[i_idx*PC_WIDTH +: PC_WIDTH];
        o_info.instr      = i_instr[i_idx*INSTR_WIDTH +: INSTR_WIDTH];
        o_info.lrd        = i_lrd[i_idx*LREG_WIDTH +: LREG_WIDTH];
        o_info.prd        = i_prd[i_idx*PREG_WIDTH +: PREG_WIDTH];
        o_info.old_prd    = i_old_prd[i_idx*PREG_WIDTH +: PREG_WIDTH];
        o_info.need_to_wb = i_need_to_wb[i_idx];
        o_info.skip       = i_skip[i_idx];
        o_info.bht.we     = i_bht_we[i_idx];
        o_info.bht.index  = i_bht_index[i_idx*BHTBTB_INDEX_WIDTH +: BHTBTB_INDEX_WIDTH];
        o_info.bht.sel    = i_bht_sel[i_idx*BHT_SEL_WIDTH +: BHT_SEL_WIDTH];
        o_info.bht.inc    = i_bht_inc[i_idx];
        o_info.bht.dec    = i_bht_dec[i_idx];
        o_info.bht.valid  = i_bht_valid[i_idx];
        o_info.btb.ce     = i_btb_ce[i_idx];
        o_info.btb.we     = i_btb_we[i_idx];
        o_info.btb.wmask  = i_btb_wmask[i_idx*BTB_WMASK_WIDTH +: BTB_WMASK_WIDTH];
        o_info.btb.index  = i_btb_index[i_idx*BTB_INDEX_WIDTH +: BTB_INDEX_WIDTH];
        o_info.btb.din    = i_btb_din[i_idx*BTB_DATA_WIDTH +: BTB_DATA_WIDTH];
    end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order ROB retire: scans the two oldest slots, commits up to two per cycle,
// and registers the commit ports plus one BHT/BTB update toward the frontend.
module rob_commit_unit
    import rob_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int unsigned PTR_W     = $clog2(ROB_DEPTH) + 1
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic                                    flush_vld,
    input  logic                                    commit_stall,
    input  logic [PTR_W-1:0]                        tail_ptr,
    input  logic [ROB_DEPTH-1:0]                    entry_ready_to_commit,
    input  logic [ROB_DEPTH*PC_WIDTH-1:0]           entry_pc,
    input  logic [ROB_DEPTH*INSTR_WIDTH-1:0]        entry_instr,
    input  logic [ROB_DEPTH*LREG_WIDTH-1:0]         entry_lrd,
    input  logic [ROB_DEPTH*PREG_WIDTH-1:0]         entry_prd,
    input  logic [ROB_DEPTH*PREG_WIDTH-1:0]         entry_old_prd,
    input  logic [ROB_DEPTH-1:0]                    entry_need_to_wb,
    input  logic [ROB_DEPTH-1:0]                    entry_skip,
    input  logic [ROB_DEPTH-1:0]                    entry_bht_write_enable,
    input  logic [ROB_DEPTH*BHTBTB_INDEX_WIDTH-1:0] entry_bht_write_index,
    input  logic [ROB_DEPTH*BHT_SEL_WIDTH-1:0]      entry_bht_write_counter_select,
    input  logic [ROB_DEPTH-1:0]                    entry_bht_write_inc,
    input  logic [ROB_DEPTH-1:0]                    entry_bht_write_dec,
    input  logic [ROB_DEPTH-1:0]                    entry_bht_valid_in,
    input  logic [ROB_DEPTH-1:0]                    entry_btb_ce,
    input  logic [ROB_DEPTH-1:0]                    entry_btb_we,
    input  logic [ROB_DEPTH*BTB_WMASK_WIDTH-1:0]    entry_btb_wmask,
    input  logic [ROB_DEPTH*BTB_INDEX_WIDTH-1:0]    entry_btb_write_index,
    input  logic [ROB_DEPTH*BTB_DATA_WIDTH-1:0]     entry_btb_din,
    output logic [ROB_DEPTH-1:0]                    commit_vld_vec,
    output logic [PTR_W-1:0]                        head_ptr,
    output logic                                    rob_empty,
    output logic [31:0]                             perf_retired_cnt,
    rob_commit_unit_if.master                       cm
);

    logic [PTR_W-1:0] r_head;
    logic [31:0]      r_perf;
    logic [PTR_W-2:0] w_h0;
    logic [PTR_W-2:0] w_h1;
    logic [PTR_W-1:0] w_occ;
    logic             w_c0;
    logic             w_c1;
    logic             w_conflict;
    rob_commit_info_t w_e0;
    rob_commit_info_t w_e1;
    cm_src_e          w_bht_src;
    cm_src_e          w_btb_src;
    rob_bht_upd_t     w_bht;
    rob_btb_upd_t     w_btb;

    assign w_h0  = r_head[PTR_W-2:0];
    assign w_h1  = w_h0 + 1'b1;
    assign w_occ = tail_ptr - r_head;

    rob_head_sel #(.ROB_DEPTH(ROB_DEPTH), .IDX_W(PTR_W-1)) u_sel_h0 (
        .i_idx(w_h0), .i_ready(entry_ready_to_commit), .i_pc(entry_pc),
        .i_instr(entry_instr), .i_lrd(entry_lrd), .i_prd(entry_prd),
        .i_old_prd(entry_old_prd), .i_need_to_wb(entry_need_to_wb), .i_skip(entry_skip),
        .i_bht_we(entry_bht_write_enable), .i_bht_index(entry_bht_write_index),
        .i_bht_sel(entry_bht_write_counter_select), .i_bht_inc(entry_bht_write_inc),
        .i_bht_dec(entry_bht_write_dec), .i_bht_valid(entry_bht_valid_in),
        .i_btb_ce(entry_btb_ce), .i_btb_we(entry_btb_we), .i_btb_wmask(entry_btb_wmask),
        .i_btb_index(entry_btb_write_index), .i_btb_din(entry_btb_din), .o_info(w_e0)
    );

    rob_head_sel #(.ROB_DEPTH(ROB_DEPTH), .IDX_W(PTR_W-1)) u_sel_h1 (
        .i_idx(w_h1), .i_ready(entry_ready_to_commit), .i_pc(entry_pc),
        .i_instr(entry_instr), .i_lrd(entry_lrd), .i_prd(entry_prd),
        .i_old_prd(entry_old_prd), .i_need_to_wb(entry_need_to_wb), .i_skip(entry_skip),
        .i_bht_we(entry_bht_write_enable), .i_bht_index(entry_bht_write_index),
        .i_bht_sel(entry_bht_write_counter_select), .i_bht_inc(entry_bht_write_inc),
        .i_bht_dec(entry_bht_write_dec), .i_bht_valid(entry_bht_valid_in),
        .i_btb_ce(entry_btb_ce), .i_btb_we(entry_btb_we), .i_btb_wmask(entry_btb_wmask),
        .i_btb_index(entry_btb_write_index), .i_btb_din(entry_btb_din), .o_info(w_e1)
    );

    // Two predictor writers in one cycle would need a second frontend port; defer h1.
    assign w_conflict = (w_e0.bht.we & w_e1.bht.we) | (w_e0.btb.we & w_e1.btb.we);
    assign w_c0 = ~flush_vld & ~commit_stall & (w_occ != '0) & w_e0.ready;
    assign w_c1 = w_c0 & (w_occ >= PTR_W'(2)) & w_e1.ready & ~w_conflict;

    always_comb begin
        commit_vld_vec       = '0;
        commit_vld_vec[w_h0] = w_c0;
        commit_vld_vec[w_h1] = w_c1;
    end

    always_comb begin
        w_bht_src = SRC_NONE;
        if (w_c0 & w_e0.bht.we)
            w_bht_src = SRC_H0;
        else if (w_c1 & w_e1.bht.we)
            w_bht_src = SRC_H1;

        w_btb_src = SRC_NONE;
        if (w_c0 & (w_e0.btb.we | w_e0.btb.ce))
            w_btb_src = SRC_H0;
        else if (w_c1 & (w_e1.btb.we | w_e1.btb.ce))
            w_btb_src = SRC_H1;

        unique case (w_bht_src)
            SRC_H0:  w_bht = w_e0.bht;
            SRC_H1:  w_bht = w_e1.bht;
            default: w_bht = '0;
        endcase
        unique case (w_btb_src)
            SRC_H0:  w_btb = w_e0.btb;
            SRC_H1:  w_btb = w_e1.btb;
            default: w_btb = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head                         <= '0;
            r_perf                         <= '0;
            cm.commit0_valid               <= 1'b0;
            cm.commit0_pc                  <= '0;
            cm.commit0_instr               <= '0;
            cm.commit0_lrd                 <= '0;
            cm.commit0_prd                 <= '0;
            cm.commit0_old_prd             <= '0;
            cm.commit0_need_to_wb          <= 1'b0;
            cm.commit0_skip                <= 1'b0;
            cm.commit1_valid               <= 1'b0;
            cm.commit1_pc                  <= '0;
            cm.commit1_instr               <= '0;
            cm.commit1_lrd                 <= '0;
            cm.commit1_prd                 <= '0;
            cm.commit1_old_prd             <= '0;
            cm.commit1_need_to_wb          <= 1'b0;
            cm.commit1_skip                <= 1'b0;
            cm.cm_bht_write_enable         <= 1'b0;
            cm.cm_bht_write_index          <= '0;
            cm.cm_bht_write_counter_select <= '0;
            cm.cm_bht_write_inc            <= 1'b0;
            cm.cm_bht_write_dec            <= 1'b0;
            cm.cm_bht_valid_in             <= 1'b0;
            cm.cm_btb_ce                   <= 1'b0;
            cm.cm_btb_we                   <= 1'b0;
            cm.cm_btb_wmask                <= '0;
            cm.cm_btb_write_index          <= '0;
            cm.cm_btb_din                  <= '0;
        end else begin
            r_head <= flush_vld ? '0 : r_head + PTR_W'(w_c0) + PTR_W'(w_c1);
            r_perf <= r_perf + 32'(w_c0) + 32'(w_c1);

            cm.commit0_valid <= w_c0;
            cm.commit1_valid <= w_c1;
            if (w_c0) begin
                cm.commit0_pc         <= w_e0.pc;
                cm.commit0_instr      <= w_e0.instr;
                cm.commit0_lrd        <= w_e0.lrd;
                cm.commit0_prd        <= w_e0.prd;
                cm.commit0_old_prd    <= w_e0.old_prd;
                cm.commit0_need_to_wb <= w_e0.need_to_wb;
                cm.commit0_skip       <= w_e0.skip;
            end
            if (w_c1) begin
                cm.commit1_pc         <= w_e1.pc;
                cm.commit1_instr      <= w_e1.instr;
                cm.commit1_lrd        <= w_e1.lrd;
                cm.commit1_prd        <= w_e1.prd;
                cm.commit1_old_prd    <= w_e1.old_prd;
                cm.commit1_need_to_wb <= w_e1.need_to_wb;
                cm.commit1_skip       <= w_e1.skip;
            end

            cm.cm_bht_write_enable         <= w_bht.we;
            cm.cm_bht_write_index          <= w_bht.index;
            cm.cm_bht_write_counter_select <= w_bht.sel;
            cm.cm_bht_write_inc            <= w_bht.inc;
            cm.cm_bht_write_dec            <= w_bht.dec;
            cm.cm_bht_valid_in             <= w_bht.valid;
            cm.cm_btb_ce                   <= w_btb.ce;
            cm.cm_btb_we                   <= w_btb.we;
            cm.cm_btb_wmask                <= w_btb.wmask;
            cm.cm_btb_write_index          <= w_btb.index;
            cm.cm_btb_din                  <= w_btb.din;
        end
    end

    assign head_ptr         = r_head;
    assign rob_empty        = (r_head == tail_ptr);
    assign perf_retired_cnt = r_perf;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: a queue-level retire model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rob_commit_unit;
    import rob_pkg::*;

    localparam int D  = 64;
    localparam int PW = 7;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic flush_vld = 1'b0;
    logic commit_stall = 1'b0;
    logic [PW-1:0] tail_ptr = '0;

    logic [D-1:0]                    entry_ready_to_commit;
    logic [D*PC_WIDTH-1:0]           entry_pc;
    logic [D*INSTR_WIDTH-1:0]        entry_instr;
    logic [D*LREG_WIDTH-1:0]         entry_lrd;
    logic [D*PREG_WIDTH-1:0]         entry_prd;
    logic [D*PREG_WIDTH-1:0]         entry_old_prd;
    logic [D-1:0]                    entry_need_to_wb;
    logic [D-1:0]                    entry_skip;
    logic [D-1:0]                    entry_bht_write_enable;
    logic [D*BHTBTB_INDEX_WIDTH-1:0] entry_bht_write_index;
    logic [D*BHT_SEL_WIDTH-1:0]      entry_bht_write_counter_select;
    logic [D-1:0]                    entry_bht_write_inc;
    logic [D-1:0]                    entry_bht_write_dec;
    logic [D-1:0]                    entry_bht_valid_in;
    logic [D-1:0]                    entry_btb_ce;
    logic [D-1:0]                    entry_btb_we;
    logic [D*BTB_WMASK_WIDTH-1:0]    entry_btb_wmask;
    logic [D*BTB_INDEX_WIDTH-1:0]    entry_btb_write_index;
    logic [D*BTB_DATA_WIDTH-1:0]     entry_btb_din;
    logic [D-1:0]                    commit_vld_vec;
    logic [PW-1:0]                   head_ptr;
    logic                            rob_empty;
    logic [31:0]                     perf_retired_cnt;

    rob_commit_unit_if cm_if();

    rob_commit_unit #(.ROB_DEPTH(D), .PTR_W(PW)) dut (
        .clock(clock), .reset_n(reset_n), .flush_vld(flush_vld), .commit_stall(commit_stall),
        .tail_ptr(tail_ptr), .entry_ready_to_commit(entry_ready_to_commit),
        .entry_pc(entry_pc), .entry_instr(entry_instr), .entry_lrd(entry_lrd),
        .entry_prd(entry_prd), .entry_old_prd(entry_old_prd),
        .entry_need_to_wb(entry_need_to_wb), .entry_skip(entry_skip),
        .entry_bht_write_enable(entry_bht_write_enable),
        .entry_bht_write_index(entry_bht_write_index),
        .entry_bht_write_counter_select(entry_bht_write_counter_select),
        .entry_bht_write_inc(entry_bht_write_inc), .entry_bht_write_dec(entry_bht_write_dec),
        .entry_bht_valid_in(entry_bht_valid_in), .entry_btb_ce(entry_btb_ce),
        .entry_btb_we(entry_btb_we), .entry_btb_wmask(entry_btb_wmask),
        .entry_btb_write_index(entry_btb_write_index), .entry_btb_din(entry_btb_din),
        .commit_vld_vec(commit_vld_vec), .head_ptr(head_ptr), .rob_empty(rob_empty),
        .perf_retired_cnt(perf_retired_cnt), .cm(cm_if)
    );

    always #5 clock = ~clock;

    // Per-entry stimulus state; data fields are fixed functions of the slot index.
    bit rdy [D];
    bit bwe [D];
    bit tce [D];
    bit twe [D];

    function automatic logic [31:0] f_pc(input int i);    return 32'h1000 + 32'(i * 4); endfunction
    function automatic logic [31:0] f_instr(input int i); return 32'h13 | 32'(i << 7);  endfunction
    function automatic logic [4:0]  f_lrd(input int i);   return 5'(i * 3);            endfunction
    function automatic logic [5:0]  f_prd(input int i);   return 6'(i + 1);            endfunction
    function automatic logic [5:0]  f_old(input int i);   return 6'(i + 33);           endfunction
    function automatic logic        f_nwb(input int i);   return (i % 2) == 1;         endfunction
    function automatic logic        f_skip(input int i);  return (i % 3) == 0;         endfunction
    function automatic logic [8:0]  f_bidx(input int i);  return 9'(i * 5 + 1);        endfunction
    function automatic logic [1:0]  f_bsel(input int i);  return 2'(i);                endfunction
    function automatic logic        f_inc(input int i);   return (i % 2) == 0;         endfunction
    function automatic logic        f_dec(input int i);   return (i % 2) == 1;         endfunction
    function automatic logic        f_bval(input int i);  return (i % 4) >= 2;         endfunction
    function automatic logic [128:0] f_wmask(input int i); return 129'(64'(i) * 64'h0101010101010101); endfunction
    function automatic logic [8:0]  f_tidx(input int i);  return 9'(300 + i);          endfunction
    function automatic logic [128:0] f_din(input int i);  return {1'b1, 64'd0, 32'hCAFE0000, f_pc(i)}; endfunction

    always_comb begin
        entry_ready_to_commit = '0; entry_pc = '0; entry_instr = '0; entry_lrd = '0;
        entry_prd = '0; entry_old_prd = '0; entry_need_to_wb = '0; entry_skip = '0;
        entry_bht_write_enable = '0; entry_bht_write_index = '0;
        entry_bht_write_counter_select = '0; entry_bht_write_inc = '0;
        entry_bht_write_dec = '0; entry_bht_valid_in = '0; entry_btb_ce = '0;
        entry_btb_we = '0; entry_btb_wmask = '0; entry_btb_write_index = '0; entry_btb_din = '0;
        for (int i = 0; i < D; i++) begin
            entry_ready_to_commit[i]             = rdy[i];
            entry_pc[i*32 +: 32]                 = f_pc(i);
            entry_instr[i*32 +: 32]              = f_instr(i);
            entry_lrd[i*5 +: 5]                  = f_lrd(i);
            entry_prd[i*6 +: 6]                  = f_prd(i);
            entry_old_prd[i*6 +: 6]              = f_old(i);
            entry_need_to_wb[i]                  = f_nwb(i);
            entry_skip[i]                        = f_skip(i);
            entry_bht_write_enable[i]            = bwe[i];
            entry_bht_write_index[i*9 +: 9]      = f_bidx(i);
            entry_bht_write_counter_select[i*2 +: 2] = f_bsel(i);
            entry_bht_write_inc[i]               = f_inc(i);
            entry_bht_write_dec[i]               = f_dec(i);
            entry_bht_valid_in[i]                = f_bval(i);
            entry_btb_ce[i]                      = tce[i];
            entry_btb_we[i]                      = twe[i];
            entry_btb_wmask[i*129 +: 129]        = f_wmask(i);
            entry_btb_write_index[i*9 +: 9]      = f_tidx(i);
            entry_btb_din[i*129 +: 129]          = f_din(i);
        end
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the ROB as a circular queue between an integer head and tail.
    int            m_head = 0;
    int            m_perf = 0;
    int            m_c0_idx = -1;
    int            m_c1_idx = -1;
    bit            m_c0v = 0;
    bit            m_c1v = 0;
    logic [14:0]   m_bht = '0;
    logic [10:0]   m_btb_ctl = '0;
    logic [128:0]  m_wmask = '0;
    logic [128:0]  m_din = '0;
    int            mn, mh0, mh1, mb, mt;

    function automatic int model_n();
        int occ, h0, h1, n;
        occ = (int'(tail_ptr) - m_head + 2 * D) % (2 * D);
        h0  = m_head % D;
        h1  = (m_head + 1) % D;
        n   = 0;
        if (!flush_vld && !commit_stall && occ >= 1 && rdy[h0]) begin
            n = 1;
            if (occ >= 2 && rdy[h1] && !(bwe[h0] && bwe[h1]) && !(twe[h0] && twe[h1]))
                n = 2;
        end
        return n;
    endfunction

    function automatic logic [82:0] exp_commit(input int i);
        if (i < 0) return '0;
        return {f_pc(i), f_instr(i), f_lrd(i), f_prd(i), f_old(i), f_nwb(i), f_skip(i)};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_head = 0; m_perf = 0; m_c0_idx = -1; m_c1_idx = -1; m_c0v = 0; m_c1v = 0;
            m_bht = '0; m_btb_ctl = '0; m_wmask = '0; m_din = '0;
        end else begin
            mn  = model_n();
            mh0 = m_head % D;
            mh1 = (m_head + 1) % D;
            m_c0v = (mn >= 1);
            m_c1v = (mn == 2);
            if (mn >= 1) m_c0_idx = mh0;
            if (mn == 2) m_c1_idx = mh1;
            mb = -1; mt = -1;
            if (mn >= 1 && bwe[mh0]) mb = mh0;
            else if (mn == 2 && bwe[mh1]) mb = mh1;
            if (mn >= 1 && (twe[mh0] || tce[mh0])) mt = mh0;
            else if (mn == 2 && (twe[mh1] || tce[mh1])) mt = mh1;
            m_bht     = (mb < 0) ? 15'd0 : {1'b1, f_bidx(mb), f_bsel(mb), f_inc(mb), f_dec(mb), f_bval(mb)};
            m_btb_ctl = (mt < 0) ? 11'd0 : {tce[mt], twe[mt], f_tidx(mt)};
            m_wmask   = (mt < 0) ? '0 : f_wmask(mt);
            m_din     = (mt < 0) ? '0 : f_din(mt);
            m_perf    = m_perf + mn;
            m_head    = flush_vld ? 0 : (m_head + mn) % (2 * D);
        end
    end

    always @(negedge clock) begin
        logic [D-1:0] ev;
        int n;
        n  = model_n();
        ev = '0;
        if (n >= 1) ev[m_head % D] = 1'b1;
        if (n == 2) ev[(m_head + 1) % D] = 1'b1;
        chk("m_vec",   256'(commit_vld_vec), 256'(ev));
        chk("m_head",  256'(head_ptr), 256'(m_head));
        chk("m_empty", 256'(rob_empty), 256'(m_head == int'(tail_ptr)));
        chk("m_perf",  256'(perf_retired_cnt), 256'(m_perf));
        chk("m_c0v",   256'(cm_if.commit0_valid), 256'(m_c0v));
        chk("m_c1v",   256'(cm_if.commit1_valid), 256'(m_c1v));
        chk("m_c0",    256'({cm_if.commit0_pc, cm_if.commit0_instr, cm_if.commit0_lrd,
                             cm_if.commit0_prd, cm_if.commit0_old_prd,
                             cm_if.commit0_need_to_wb, cm_if.commit0_skip}),
                       256'(exp_commit(m_c0_idx)));
        chk("m_c1",    256'({cm_if.commit1_pc, cm_if.commit1_instr, cm_if.commit1_lrd,
                             cm_if.commit1_prd, cm_if.commit1_old_prd,
                             cm_if.commit1_need_to_wb, cm_if.commit1_skip}),
                       256'(exp_commit(m_c1_idx)));
        chk("m_bht",   256'({cm_if.cm_bht_write_enable, cm_if.cm_bht_write_index,
                             cm_if.cm_bht_write_counter_select, cm_if.cm_bht_write_inc,
                             cm_if.cm_bht_write_dec, cm_if.cm_bht_valid_in}), 256'(m_bht));
        chk("m_btb",   256'({cm_if.cm_btb_ce, cm_if.cm_btb_we, cm_if.cm_btb_write_index}),
                       256'(m_btb_ctl));
        chk("m_wmask", 256'(cm_if.cm_btb_wmask), 256'(m_wmask));
        chk("m_din",   256'(cm_if.cm_btb_din), 256'(m_din));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < D; i++) begin
            rdy[i] = 0; bwe[i] = 0; tce[i] = 0; twe[i] = 0;
        end
        repeat (2) @(posedge clock);
        #1;
        chk("rst_empty", 256'(rob_empty), 256'(1));
        chk("rst_vec",   256'(commit_vld_vec), 256'(0));
        chk("rst_head",  256'(head_ptr), 256'(0));
        chk("rst_perf",  256'(perf_retired_cnt), 256'(0));
        chk("rst_c0v",   256'(cm_if.commit0_valid), 256'(0));
        reset_n = 1'b1;
        tick();

        // Three ready entries: pair then single.
        rdy[0] = 1; rdy[1] = 1; rdy[2] = 1; tail_ptr = 7'd3;
        @(negedge clock); chk("basic_vec1", 256'(commit_vld_vec), 256'(64'h3));
        tick();
        chk("basic_head1", 256'(head_ptr), 256'(2));
        chk("basic_pc0",   256'(cm_if.commit0_pc), 256'(32'h1000));
        chk("basic_pc1",   256'(cm_if.commit1_pc), 256'(32'h1004));
        @(negedge clock); chk("basic_vec2", 256'(commit_vld_vec), 256'(64'h4));
        tick();
        chk("basic_head2", 256'(head_ptr), 256'(3));
        chk("basic_pc2",   256'(cm_if.commit0_pc), 256'(32'h1008));
        chk("basic_c1v",   256'(cm_if.commit1_valid), 256'(0));
        chk("basic_perf",  256'(perf_retired_cnt), 256'(3));

        // Flush beats ready entries.
        for (int i = 3; i <= 6; i++) rdy[i] = 1;
        tail_ptr = 7'd7; flush_vld = 1'b1;
        @(negedge clock); chk("flush_vec", 256'(commit_vld_vec), 256'(0));
        tick();
        chk("flush_head", 256'(head_ptr), 256'(0));
        chk("flush_c0v",  256'(cm_if.commit0_valid), 256'(0));
        flush_vld = 1'b0; tail_ptr = 7'd0;
        for (int i = 0; i < D; i++) rdy[i] = 0;

        // Predictor conflict, then independent BHT/BTB sources in one pair.
        for (int i = 0; i <= 3; i++) rdy[i] = 1;
        bwe[0] = 1; bwe[1] = 1; twe[2] = 1; tce[2] = 1; bwe[3] = 1; tail_ptr = 7'd2;
        @(negedge clock); chk("conf_vec1", 256'(commit_vld_vec), 256'(64'h1));
        tick();
        chk("conf_bht_en1",  256'(cm_if.cm_bht_write_enable), 256'(1));
        chk("conf_bht_idx1", 256'(cm_if.cm_bht_write_index), 256'(9'd1));
        @(negedge clock); chk("conf_vec2", 256'(commit_vld_vec), 256'(64'h2));
        tick();
        chk("conf_bht_idx2", 256'(cm_if.cm_bht_write_index), 256'(9'd6));
        tail_ptr = 7'd4;
        @(negedge clock); chk("mix_vec", 256'(commit_vld_vec), 256'(64'hC));
        tick();
        chk("mix_bht_idx", 256'(cm_if.cm_bht_write_index), 256'(9'd16));
        chk("mix_btb_idx", 256'(cm_if.cm_btb_write_index), 256'(9'd302));
        chk("mix_btb_we",  256'(cm_if.cm_btb_we), 256'(1));
        tick();
        chk("pulse_bht", 256'(cm_if.cm_bht_write_enable), 256'(0));
        chk("pulse_btb", 256'(cm_if.cm_btb_we), 256'(0));
        for (int i = 0; i < D; i++) begin
            bwe[i] = 0; tce[i] = 0; twe[i] = 0;
        end

        // Stall holds head; single-entry ROB never commits slot 1.
        rdy[4] = 1; rdy[5] = 1; tail_ptr = 7'd5; commit_stall = 1'b1;
        @(negedge clock); chk("stall_vec", 256'(commit_vld_vec), 256'(0));
        tick();
        chk("stall_head", 256'(head_ptr), 256'(4));
        commit_stall = 1'b0;
        @(negedge clock); chk("single_vec", 256'(commit_vld_vec), 256'(64'h10));
        tick();
        chk("single_head", 256'(head_ptr), 256'(5));

        // Drain up to slot 63, then straddle the wrap.
        for (int i = 0; i < D; i++) rdy[i] = 1;
        tail_ptr = 7'd63;
        for (int k = 0; k < 40 && head_ptr != 7'd63; k++) tick();
        chk("wrap_reach", 256'(head_ptr), 256'(63));
        tail_ptr = 7'd65;
        @(negedge clock); chk("wrap_vec", 256'(commit_vld_vec), 256'(64'h8000_0000_0000_0001));
        tick();
        chk("wrap_head", 256'(head_ptr), 256'(65));
        chk("wrap_pc0",  256'(cm_if.commit0_pc), 256'(32'h10FC));
        chk("wrap_pc1",  256'(cm_if.commit1_pc), 256'(32'h1000));
        chk("wrap_full", 256'(rob_empty), 256'(1));

        // Asynchronous reset in the middle of retiring.
        tail_ptr = 7'd69;
        tick();
        chk("mid_head", 256'(head_ptr), 256'(67));
        reset_n = 1'b0; tail_ptr = 7'd0;
        #1;
        chk("arst_head", 256'(head_ptr), 256'(0));
        chk("arst_perf", 256'(perf_retired_cnt), 256'(0));
        chk("arst_c0v",  256'(cm_if.commit0_valid), 256'(0));
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
